// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 frame receiver
package ps2_pkg;

    localparam int FRAME_LEN = 11;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    // The first data bit (d0) lands in frame bit 9, so the scan code is the
    // data field read back in reverse: code[i] = frame[9-i].
    function automatic logic [7:0] frame_code(input logic [FRAME_LEN-1:0] frame);
        logic [7:0] c;
        for (int i = 0; i < 8; i++) begin
            c[i] = frame[9-i];
        end
        return c;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// rtl/ps2_sync.sv - two-flop synchronizer with falling-edge detect
module ps2_sync (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic sync,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Next values of the synchronizer chain.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // Chain loads 1 on reset so an idle bus does not look like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sync = sync2_q;
    assign fall = sync2_q & ~sync1_q;

endmodule

// File: rtl/ps2_frame_ctrl.sv
// rtl/ps2_frame_ctrl.sv - PS/2 keyboard frame receiver with break/extended handling
module ps2_frame_ctrl
    import ps2_pkg::*;
#(
    parameter int N       = FRAME_LEN,
    parameter int TIMEOUT = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic [N-1:0] q,
    output logic [7:0]   code,
    output logic         q_valid,
    output logic         ext,
    output logic         err
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    logic clk_sync_unused;
    logic clk_fall;
    logic data_sync;
    logic data_fall_unused;

    ps2_sync u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk),
        .sync  (clk_sync_unused),
        .fall  (clk_fall)
    );

    ps2_sync u_data_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_data),
        .sync  (data_sync),
        .fall  (data_fall_unused)
    );

    state_t          state_q, state_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            brk_q, brk_d;
    logic            ext_pend_q, ext_pend_d;
    logic [N-1:0]    q_q, q_d;
    logic [7:0]      code_q, code_d;
    logic            ext_q, ext_d;
    logic            q_valid_q, q_valid_d;
    logic            err_q, err_d;

    logic            frame_ok;
    logic [7:0]      frame_c;

    // Frame validity: start low, stop high, odd parity over data plus parity.
    always_comb begin
        frame_ok = (shreg_q[N-1] == 1'b0) && (shreg_q[0] == 1'b1) && (^shreg_q[N-2:1] == 1'b1);
        frame_c  = frame_code(shreg_q);
    end

    // Next-state logic: bit collection, timeout supervision, and code decoding.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        count_d    = count_q;
        to_d       = to_q;
        brk_d      = brk_q;
        ext_pend_d = ext_pend_q;
        q_d        = q_q;
        code_d     = code_q;
        ext_d      = ext_q;
        q_valid_d  = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (clk_fall) begin
                    shreg_d = {shreg_q[N-2:0], data_sync};
                    to_d    = '0;
                    if (!data_sync) begin
                        state_d = SHIFT;
                        count_d = CNT_W'(1);
                    end
                end
            end

            SHIFT: begin
                if (clk_fall) begin
                    shreg_d = {shreg_q[N-2:0], data_sync};
                    to_d    = '0;
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_W'(N - 1)) begin
                        state_d = CHECK;
                    end
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    // Keyboard stalled mid-frame: drop the partial frame.
                    err_d   = 1'b1;
                    count_d = '0;
                    to_d    = '0;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end

            CHECK: begin
                // Edges in this single cycle are ignored; legal PS/2 traffic is far slower.
                state_d = IDLE;
                count_d = '0;
                if (!frame_ok) begin
                    err_d      = 1'b1;
                    brk_d      = 1'b0;
                    ext_pend_d = 1'b0;
                end else if (frame_c == BREAK_CODE) begin
                    brk_d = 1'b1;
                end else if (frame_c == EXT_CODE) begin
                    ext_pend_d = 1'b1;
                end else if (brk_q) begin
                    // Release of a key: swallow it and reset the prefix state.
                    brk_d      = 1'b0;
                    ext_pend_d = 1'b0;
                end else begin
                    q_d        = shreg_q;
                    code_d     = frame_c;
                    ext_d      = ext_pend_q;
                    q_valid_d  = 1'b1;
                    ext_pend_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single register stage for FSM state, datapath and all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            count_q    <= '0;
            to_q       <= '0;
            brk_q      <= 1'b0;
            ext_pend_q <= 1'b0;
            q_q        <= '0;
            code_q     <= '0;
            ext_q      <= 1'b0;
            q_valid_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            count_q    <= count_d;
            to_q       <= to_d;
            brk_q      <= brk_d;
            ext_pend_q <= ext_pend_d;
            q_q        <= q_d;
            code_q     <= code_d;
            ext_q      <= ext_d;
            q_valid_q  <= q_valid_d;
            err_q      <= err_d;
        end
    end

    assign q       = q_q;
    assign code    = code_q;
    assign ext     = ext_q;
    assign q_valid = q_valid_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ps2_frame_ctrl.sv
// tb/tb_ps2_frame_ctrl.sv - scoreboard bench for ps2_frame_ctrl
module tb_ps2_frame_ctrl;

    localparam int TO = 200;

    logic        clk;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] q;
    logic [7:0]  code;
    logic        q_valid;
    logic        ext;
    logic        err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        bit          is_err;
        logic [10:0] q;
        logic [7:0]  code;
        logic        ext;
        int          at_cyc;
    } exp_t;

    exp_t exp_q[$];

    ps2_frame_ctrl #(.N(11), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .q        (q),
        .code     (code),
        .q_valid  (q_valid),
        .ext      (ext),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit is_err, input logic [10:0] eq, input logic [7:0] ec,
                        input logic ee, input int at);
        exp_t e;
        e.is_err = is_err;
        e.q      = eq;
        e.code   = ec;
        e.ext    = ee;
        e.at_cyc = at;
        exp_q.push_back(e);
    endtask

    // kind: 0 = no output expected, 1 = q_valid expected, 2 = err expected
    task automatic send_frame(input logic [7:0] c, input bit flip, input int nbits,
                              input int kind, input logic [10:0] eq, input logic [7:0] ec,
                              input logic ee);
        logic [10:0] bits;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = c[i];
        bits[9]  = (~^c) ^ flip;
        bits[10] = 1'b1;
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            ps2_data = bits[k];
            repeat (8) @(negedge clk);
            ps2_clk = 1'b0;
            if (k == 10 && kind != 0) push(kind == 2, eq, ec, ee, cyc + 3);
            repeat (8) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Monitor: every q_valid/err pulse is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && (q_valid || err)) begin
                check("valid_err_exclusive", {31'b0, q_valid & err}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'b0, q_valid, err}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("event_kind_err", {31'b0, err}, {31'b0, e.is_err});
                    if (e.at_cyc >= 0) check("event_latency", cyc, e.at_cyc);
                    if (!e.is_err) begin
                        check("q", {21'b0, q}, {21'b0, e.q});
                        check("code", {24'b0, code}, {24'b0, e.code});
                        check("ext", {31'b0, ext}, {31'b0, e.ext});
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_q"}, {21'b0, q}, 32'd0);
        check({tag, "_code"}, {24'b0, code}, 32'd0);
        check({tag, "_ext"}, {31'b0, ext}, 32'd0);
        check({tag, "_q_valid"}, {31'b0, q_valid}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Plain make code 16.
        send_frame(8'h16, 1'b0, 11, 1, 11'b00110100001, 8'h16, 1'b0);

        // Break sequence F0 16: nothing reported, q holds.
        send_frame(8'hF0, 1'b0, 11, 0, 11'b0, 8'h0, 1'b0);
        send_frame(8'h16, 1'b0, 11, 0, 11'b0, 8'h0, 1'b0);
        check("break_q_hold", {21'b0, q}, {21'b0, 11'b00110100001});
        check("break_code_hold", {24'b0, code}, 32'h16);

        // Extended E0 75, then plain 1C.
        send_frame(8'hE0, 1'b0, 11, 0, 11'b0, 8'h0, 1'b0);
        send_frame(8'h75, 1'b0, 11, 1, 11'b01010111001, 8'h75, 1'b1);
        send_frame(8'h1C, 1'b0, 11, 1, 11'b00011100001, 8'h1C, 1'b0);

        // Parity error, then good 1E.
        send_frame(8'h16, 1'b1, 11, 2, 11'b0, 8'h0, 1'b0);
        check("parity_q_hold", {21'b0, q}, {21'b0, 11'b00011100001});
        send_frame(8'h1E, 1'b0, 11, 1, 11'b00111100011, 8'h1E, 1'b0);

        // Truncated frame times out, then a full frame decodes.
        push(1'b1, 11'b0, 8'h0, 1'b0, -1);
        send_frame(8'h16, 1'b0, 5, 0, 11'b0, 8'h0, 1'b0);
        repeat (TO + 10) @(negedge clk);
        send_frame(8'h16, 1'b0, 11, 1, 11'b00110100001, 8'h16, 1'b0);

        // Reset mid-frame discards the partial frame silently.
        send_frame(8'h75, 1'b0, 6, 0, 11'b0, 8'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("midrst");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(8'h16, 1'b0, 11, 1, 11'b00110100001, 8'h16, 1'b0);

        repeat (50) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
